// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Produces DIGITS packed BCD digits with a done strobe and an overflow flag.
module bin_to_bcd_seq #(
  parameter int W      = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);
  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [BW-1:0]   scr_q, scr_d;
  logic            sovf_q, sovf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   scr_n;
  logic [W-1:0]    sh_n;
  logic            sovf_n;
  logic            last;

  // Digit correction happens before the shift, so every digit stays within 0..9.
  always_comb begin
    adj = scr_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    scr_n  = {adj[BW-2:0], sh_q[W-1]};
    sh_n   = {sh_q[W-2:0], 1'b0};
    sovf_n = sovf_q | adj[BW-1];
    last   = (cnt_q == CW'(W - 1));
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    sovf_d  = sovf_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          sh_d    = bin;
          scr_d   = '0;
          sovf_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sh_d   = sh_n;
        scr_d  = scr_n;
        sovf_d = sovf_n;
        cnt_d  = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          bcd_d   = scr_n;
          ovf_d   = sovf_n;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      scr_q   <= '0;
      sovf_q  <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      sovf_q  <= sovf_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (default and W=8/DIGITS=3 instances).
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin = '0;
  logic        busy, done, ovf;
  logic [15:0] bcd;

  logic        start8 = 1'b0;
  logic [7:0]  bin8 = '0;
  logic        busy8, done8, ovf8;
  logic [11:0] bcd8;

  int pass_cnt = 0;
  int total = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.W(16), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
  );

  bin_to_bcd_seq #(.W(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .bcd(bcd8), .ovf(ovf8)
  );

  always @(negedge clk) begin
    if ((busy && done) || (busy8 && done8)) overlap++;
  end

  // Drives one conversion; returns edges from accept to done and busy-high cycles.
  task automatic convert(input logic [15:0] b, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1;
    bin   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = 16'hFFFF;
    bcnt  = busy ? 1 : 0;
    lat   = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    total++; if (busy !== 1'b0)   $display("FAIL reset_busy got=%b want=0", busy);   else pass_cnt++;
    total++; if (done !== 1'b0)   $display("FAIL reset_done got=%b want=0", done);   else pass_cnt++;
    total++; if (bcd !== 16'h0)   $display("FAIL reset_bcd got=%h want=0000", bcd);  else pass_cnt++;
    total++; if (ovf !== 1'b0)    $display("FAIL reset_ovf got=%b want=0", ovf);     else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero;
    int lat, bc;
    convert(16'd0, lat, bc);
    total++; if (lat !== 16)      $display("FAIL zero_latency got=%0d want=16", lat); else pass_cnt++;
    total++; if (bc !== 16)       $display("FAIL zero_busy_cycles got=%0d want=16", bc); else pass_cnt++;
    total++; if (busy !== 1'b0)   $display("FAIL zero_busy_in_done got=%b want=0", busy); else pass_cnt++;
    total++; if (bcd !== 16'h0)   $display("FAIL zero_bcd got=%h want=0000", bcd);   else pass_cnt++;
    total++; if (ovf !== 1'b0)    $display("FAIL zero_ovf got=%b want=0", ovf);      else pass_cnt++;
    @(posedge clk); #1;
    total++; if (done !== 1'b0)   $display("FAIL zero_done_one_cycle got=%b want=0", done); else pass_cnt++;
  endtask

  task automatic test_values;
    logic [15:0] vin [6]  = '{16'd1234, 16'd9999, 16'd10000, 16'd65535, 16'd7, 16'd1000};
    logic [15:0] vbcd [6] = '{16'h1234, 16'h9999, 16'h0000, 16'h5535, 16'h0007, 16'h1000};
    logic        vovf [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      convert(vin[i], lat, bc);
      total++; if (done !== 1'b1) $display("FAIL val_done bin=%0d got=%b want=1", vin[i], done); else pass_cnt++;
      total++; if (bcd !== vbcd[i]) $display("FAIL val_bcd bin=%0d got=%h want=%h", vin[i], bcd, vbcd[i]); else pass_cnt++;
      total++; if (ovf !== vovf[i]) $display("FAIL val_ovf bin=%0d got=%b want=%b", vin[i], ovf, vovf[i]); else pass_cnt++;
    end
    repeat (3) @(posedge clk);
    #1;
    total++; if (bcd !== 16'h1000) $display("FAIL hold_bcd got=%h want=1000", bcd); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat, dcnt;
    @(negedge clk);
    start = 1'b1; bin = 16'd42;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; dcnt = 0;
    while (lat < 40) begin
      if (lat == 3 || lat == 4) begin start = 1'b1; bin = 16'd999; end
      else if (lat == 5) start = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (done) begin dcnt++; break; end
    end
    total++; if (lat !== 16)     $display("FAIL b2b_first_latency got=%0d want=16", lat); else pass_cnt++;
    total++; if (bcd !== 16'h0042) $display("FAIL b2b_ignore_start_bcd got=%h want=0042", bcd); else pass_cnt++;
    start = 1'b1; bin = 16'd999;
    @(posedge clk); #1;
    start = 1'b0; bin = 16'd0;
    total++; if (busy !== 1'b1)  $display("FAIL b2b_accept_in_done got=%b want=1", busy); else pass_cnt++;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    total++; if (lat !== 16)     $display("FAIL b2b_second_latency got=%0d want=16", lat); else pass_cnt++;
    total++; if (bcd !== 16'h0999) $display("FAIL b2b_second_bcd got=%h want=0999", bcd); else pass_cnt++;
    total++; if (dcnt !== 1)     $display("FAIL b2b_first_done_count got=%0d want=1", dcnt); else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    int lat, bc, dcnt;
    convert(16'd1234, lat, bc);
    total++; if (bcd !== 16'h1234) $display("FAIL mid_pre_bcd got=%h want=1234", bcd); else pass_cnt++;
    @(negedge clk);
    start = 1'b1; bin = 16'd5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0)   $display("FAIL mid_rst_busy got=%b want=0", busy); else pass_cnt++;
    total++; if (done !== 1'b0)   $display("FAIL mid_rst_done got=%b want=0", done); else pass_cnt++;
    total++; if (bcd !== 16'h0)   $display("FAIL mid_rst_bcd got=%h want=0000", bcd); else pass_cnt++;
    total++; if (ovf !== 1'b0)    $display("FAIL mid_rst_ovf got=%b want=0", ovf); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    total++; if (dcnt !== 0)      $display("FAIL mid_rst_no_done got=%0d want=0", dcnt); else pass_cnt++;
    convert(16'd5678, lat, bc);
    total++; if (bcd !== 16'h5678) $display("FAIL mid_rst_retry_bcd got=%h want=5678", bcd); else pass_cnt++;
    total++; if (ovf !== 1'b0)    $display("FAIL mid_rst_retry_ovf got=%b want=0", ovf); else pass_cnt++;
  endtask

  task automatic test_small_params;
    int lat;
    @(negedge clk);
    start8 = 1'b1; bin8 = 8'd255;
    @(posedge clk); #1;
    start8 = 1'b0; bin8 = 8'd0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done8) break;
    end
    total++; if (lat !== 8)       $display("FAIL w8_latency got=%0d want=8", lat); else pass_cnt++;
    total++; if (bcd8 !== 12'h255) $display("FAIL w8_bcd got=%h want=255", bcd8); else pass_cnt++;
    total++; if (ovf8 !== 1'b0)   $display("FAIL w8_ovf got=%b want=0", ovf8); else pass_cnt++;
  endtask

  task automatic test_exclusive;
    total++; if (overlap !== 0)   $display("FAIL busy_done_overlap got=%0d want=0", overlap); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_back_to_back();
    test_mid_reset();
    test_small_params();
    test_exclusive();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that turns the calculator's binary result into packed BCD digits for the digit registers and the seven-segment display path. It sits directly downstream of the arithmetic unit that produces the 16-bit `number` result. It accepts a start pulse, converts over W cycles, then presents the digits with a one-cycle `done` strobe and a sticky overflow flag when the value does not fit in DIGITS decimal digits.

## Interface
- `W`, default 16: width of the binary input; it is also the conversion length in cycles.
- `DIGITS`, default 4: number of BCD digits produced.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `start`  in  1: conversion request; sampled on a `clk` edge while not busy.
- `bin`  in  W: unsigned binary value; sampled on the accepting edge only.
- `busy`  out  1: high while a conversion is in progress.
- `done`  out  1: one-cycle strobe; `bcd` and `ovf` are valid and newly updated.
- `bcd`  out  4*DIGITS: packed BCD, digit 0 (units) in bits [3:0]; holds the last result.
- `ovf`  out  1: high when the last converted value was ≥ 10^DIGITS.

## Operation
- States:
  - IDLE: waiting for a request.
  - SHIFT: W iterations.
  - DONE: single cycle; `done`=1.
- Transitions:
  - IDLE/DONE → SHIFT on `start`=1.
  - DONE → IDLE otherwise.
  - SHIFT → DONE after W iterations.
- Accepting edge:
  - Latch `bin` into a W-bit shift register.
  - Clear the 4*DIGITS-bit scratch register and the scratch overflow bit.
  - Clear the iteration counter (width ceil(log2(W+1))).
- Each SHIFT cycle, in order:
  - For every scratch digit ≥ 5, add 3 (4-bit, no carry between digits).
  - Shift {scratch, shiftreg} left by 1.
  - OR the bit leaving the scratch MSB into the scratch overflow bit.
  - Increment the counter.
- On the edge that completes iteration W:
  - `bcd` takes the final scratch value.
  - `ovf` takes the final overflow bit, i.e. 1 iff some 1 was shifted out of the top digit.
  - `done` is set to 1.
  - For an overflowed value, `bcd` holds the low DIGITS decimal digits (value mod 10^DIGITS).
- `start` while in SHIFT is ignored. No queueing; the in-flight conversion is unaffected.
- `start` during the DONE cycle is accepted, giving back-to-back conversions.
- `bin` changes after the accepting edge have no effect.
- `bcd`/`ovf` change only on the edge that sets `done`; between conversions they hold.
- Reset (any time, including mid-SHIFT):
  - State → IDLE; the conversion is aborted with no `done`.
  - `busy`=0, `done`=0, `bcd`=0, `ovf`=0.
  - Scratch, shift register and counter are cleared.

## Timing
- Start accepted at edge k:
  - `busy` is high after edges k … k+W−1.
  - `done`=1 after edge k+W, for exactly one cycle; `busy`=0 in that cycle.
- Latency, accept edge to `done`: W cycles (16 with defaults). Throughput: one conversion per W+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `done` and `busy` are never high together.

## Test plan
- Reset, then `bin`=0, one-cycle `start` → `done` exactly 16 cycles after the accepting edge; `bcd`=0x0000, `ovf`=0; `busy` high for 16 cycles.
- `bin`=1234 (0x04D2) → `bcd`=0x1234, `ovf`=0. `bin`=9999 → `bcd`=0x9999, `ovf`=0.
- `bin`=10000 → `bcd`=0x0000, `ovf`=1. `bin`=65535 → `bcd`=0x5535, `ovf`=1. A following `bin`=7 → `bcd`=0x0007, `ovf`=0 (overflow not carried over).
- `start` with `bin`=42, then `start` pulses and `bin`=999 during SHIFT → single `done`, `bcd`=0x0042. `start` with `bin`=999 held in the DONE cycle → second `done` 16 cycles later, `bcd`=0x0999.
- Convert 1234, then start 5678 and assert `rst` at iteration 8 → all outputs 0 immediately (asynchronous); no `done`; the next conversion of 5678 yields 0x5678.
- Parameter sweep W=8, DIGITS=3: `bin`=255 → `bcd`=0x255, `ovf`=0, `done` 8 cycles after accept.
